quad_lane_merge: RTL and testbench
==================================

Name: quad_lane_merge

Overview:
- Downstream collector for a four-lane macro fabric: one wide source macro fans out into four single-width pipeline chains, and this block consumes the chain ends.
- Each lane is buffered in a small FIFO.
- A round-robin arbiter merges the lanes into one tagged output stream with valid/ready flow control.
- Used as the standard-cell sink stage in macro-placement connectivity test designs.

Parameters:
- DW, 8, data width per lane.
- DEPTH, 4, entries per lane FIFO; power of two, >= 2.
- AW, 2, pointer width = log2(DEPTH).

Ports:
- clk  input  1  single clock; all flops rising-edge.
- rst_n  input  1  asynchronous active-low reset; deassertion is synchronous to clk externally.
- in_valid  input  4  per-lane valid; bit i = lane i.
- in_data  input  4*DW  lane i occupies bits [i*DW +: DW].
- in_ready  output  4  per-lane ready; bit i = lane i FIFO not full.
- out_valid  output  1  merged stream valid.
- out_data  output  DW  merged data.
- out_lane  output  2  source lane index of the current out_data.
- out_ready  input  1  downstream accept.
- lane_full  output  4  per-lane FIFO full status.
- drop_err  output  1  sticky flag: a push was attempted while the lane was not ready.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All FIFO pointers and counts = 0.
  - Arbiter priority pointer = 0.
  - Output register empty: out_valid = 0, out_data = 0, out_lane = 0.
  - lane_full = 0, in_ready = 4'b1111, drop_err = 0.
- Reset mid-operation discards all buffered data with no partial output; the first cycle after deassert behaves as post-reset.
- Lane FIFO i:
  - Push when in_valid[i] & in_ready[i].
  - Pop when the arbiter grants lane i.
  - count_i is AW+1 bits.
  - in_ready[i] = (count_i != DEPTH); lane_full[i] = (count_i == DEPTH).
  - Simultaneous push and pop when full is not allowed (ready is already low); when empty, push and pop cannot coincide because pop requires a non-empty FIFO.
  - Pointers wrap modulo DEPTH.
- drop_err sets when in_valid[i] & ~in_ready[i] for any i. It clears only on reset.
- Output register (single stage):
  - load_en = ~out_valid | out_ready.
  - When load_en is high and any FIFO is non-empty, the arbiter grants exactly one lane.
  - The granted lane's head word goes to out_data, its index to out_lane, and out_valid is set to 1.
  - When load_en is high and all FIFOs are empty, out_valid goes to 0.
  - While out_valid & ~out_ready, out_data and out_lane hold stable and no pop occurs.
- Latency: a word pushed into an empty lane while the output register is free appears on out_valid at the next rising edge after the push edge (2-cycle push-to-output minimum). No combinational path from in_valid to out_valid.
- Throughput: 1 word/cycle sustained when out_ready = 1.
- Arbiter: round-robin.
  - Search order starts at ptr, then ptr+1 ... ptr+3, mod 4.
  - After a grant to lane g, ptr = g+1 mod 4. With no grant, ptr holds.
  - This guarantees no lane waits more than 3 grants while non-empty.
- Arbiter state machine, 2 states:
  - IDLE: no FIFO holds data and the output register is empty.
  - ACTIVE: otherwise.
  - IDLE->ACTIVE on any push.
  - ACTIVE->IDLE when the last word is accepted and all FIFOs are empty with no push in that cycle.
  - The state is observable only through out_valid timing and has no extra port.
- FIFO storage is flops (no macro RAM). Widths are fixed by DW; there is no arithmetic beyond pointer increment and count +/-1.

Optional Feature:
- Macro QUAD_LANE_MERGE_PARITY_EN.
- When defined:
  - Adds output port out_par (1 bit) = even parity (XOR reduction) of {out_lane, out_data}, registered with the output stage.
  - Adds input port in_par (4 bits), one per lane. A push whose data parity mismatches in_par[i] still stores the data and sets sticky bit par_err (added output, reset 0).
- When undefined: none of these ports or flops exist, and behaviour is otherwise identical.

Test Plan:
1. Reset with in_valid = 4'b1111 held asserted.
   - During reset: in_ready = 4'b1111, out_valid = 0.
   - After deassert: lanes 0..3 accepted, output order 0,1,2,3.
2. Lanes 0 and 2 each push DEPTH words 0xA0..0xA3 / 0xC0..0xC3 with out_ready = 1. Output must alternate lane 0/2 strictly: A0,C0,A1,C1,... with matching out_lane.
3. out_ready = 0 while lane 1 pushes 5 words, DEPTH = 4.
   - The first word goes to the output register and 4 words go to the FIFO.
   - lane_full[1] = 1, in_ready[1] = 0.
   - A 6th push attempt sets drop_err = 1.
4. Stall hold: out_valid = 1, out_ready = 0 for 10 cycles. out_data and out_lane stay constant. Releasing out_ready yields the next word the following cycle.
5. Pulse rst_n low asynchronously mid-burst, between clock edges.
   - out_valid drops immediately, and all counts are cleared.
   - A new push of 0x5A on lane 3 appears with out_lane = 3 two edges later.
6. With QUAD_LANE_MERGE_PARITY_EN defined, push 0x07 on lane 1 with in_par[1] = 0, which mismatches the data.
   - par_err = 1.
   - out_par = ^{2'b01, 8'h07} = 0.

Source files
------------

// File: rtl/quad_lane_merge.sv
// Four-lane collector: per-lane flop FIFOs merged round-robin into one tagged valid/ready stream.
// Optional parity checking/generation is enabled with QUAD_LANE_MERGE_PARITY_EN.
module quad_lane_merge #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      in_valid,
  input  logic [4*DW-1:0] in_data,
  output logic [3:0]      in_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [1:0]      out_lane,
  input  logic            out_ready,
`ifdef QUAD_LANE_MERGE_PARITY_EN
  input  logic [3:0]      in_par,
  output logic            out_par,
  output logic            par_err,
`endif
  output logic [3:0]      lane_full,
  output logic            drop_err
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state;

  logic [3:0]    push;
  logic [3:0]    pop;
  logic [3:0]    nonempty;
  logic [3:0]    lane_par;
  logic [DW-1:0] head [4];

  logic          load_en;
  logic          grant_valid;
  logic [1:0]    grant;
  logic [1:0]    ptr;
  logic [1:0]    idx;

  assign load_en = ~out_valid | out_ready;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    assign in_ready[i]  = (count != FULL_CNT);
    assign lane_full[i] = (count == FULL_CNT);
    assign nonempty[i]  = (count != '0);
    assign push[i]      = in_valid[i] & in_ready[i];
    assign pop[i]       = grant_valid & (grant == 2'(i));
    assign head[i]      = mem[rd_ptr];
    assign lane_par[i]  = ^in_data[i*DW +: DW];

    // Storage has no reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
      if (push[i]) mem[wr_ptr] <= in_data[i*DW +: DW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[i]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[i])  rd_ptr <= rd_ptr + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Walk offsets high to low so the lane closest to ptr wins.
  always_comb begin
    grant_valid = 1'b0;
    grant       = ptr;
    idx         = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (nonempty[idx]) begin
        grant_valid = load_en;
        grant       = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_lane  <= 2'd0;
      drop_err  <= 1'b0;
    end else begin
      if (load_en) begin
        out_valid <= grant_valid;
        if (grant_valid) begin
          out_data <= head[grant];
          out_lane <= grant;
          ptr      <= grant + 2'd1;
        end
      end
      if (|(in_valid & ~in_ready)) drop_err <= 1'b1;
    end
  end

  // Tracks whether anything is in flight; it has no port of its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (|push) state <= ACTIVE;
        ACTIVE:  if (~|push && ~|nonempty && load_en) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef QUAD_LANE_MERGE_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_par <= 1'b0;
      par_err <= 1'b0;
    end else begin
      if (grant_valid) out_par <= ^{grant, head[grant]};
      if (|(push & (lane_par ^ in_par))) par_err <= 1'b1;
    end
  end
`else
  logic unused_par;
  assign unused_par = ^lane_par;
`endif

endmodule

// File: tb/tb_quad_lane_merge.sv
// Directed bench for quad_lane_merge: vector table for ordering/arbitration plus
// hand-written sequences for backpressure, stall hold, async reset and parity.
module tb_quad_lane_merge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_lane;
  logic        out_ready;
  logic [3:0]  lane_full;
  logic        drop_err;
`ifdef QUAD_LANE_MERGE_PARITY_EN
  logic [3:0]  in_par;
  logic        out_par;
  logic        par_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  quad_lane_merge #(.DW(8), .DEPTH(4), .AW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_lane  (out_lane),
    .out_ready (out_ready),
`ifdef QUAD_LANE_MERGE_PARITY_EN
    .in_par    (in_par),
    .out_par   (out_par),
    .par_err   (par_err),
`endif
    .lane_full (lane_full),
    .drop_err  (drop_err)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic        ready;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic [1:0]  exp_lane;
    logic [3:0]  exp_in_ready;
  } vec_t;

  vec_t vecs [16];

  task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(4'b0000, 32'h0, 1'b1);
    rst_n = 1'b0;
    step();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Test 1 (0..5): all lanes push once after reset; test 2 (6..15): lanes 0/2 alternate.
    vecs[0]  = '{4'b1111, 32'h13121110, 1'b1, 1'b0, 8'h00, 2'd0, 4'b1111};
    vecs[1]  = '{4'b0000, 32'h0,        1'b1, 1'b1, 8'h10, 2'd0, 4'b1111};
    vecs[2]  = '{4'b0000, 32'h0,        1'b1, 1'b1, 8'h11, 2'd1, 4'b1111};
    vecs[3]  = '{4'b0000, 32'h0,        1'b1, 1'b1, 8'h12, 2'd2, 4'b1111};
    vecs[4]  = '{4'b0000, 32'h0,        1'b1, 1'b1, 8'h13, 2'd3, 4'b1111};
    vecs[5]  = '{4'b0000, 32'h0,        1'b1, 1'b0, 8'h00, 2'd0, 4'b1111};
    vecs[6]  = '{4'b0101, 32'h00C000A0, 1'b1, 1'b0, 8'h00, 2'd0, 4'b1111};
    vecs[7]  = '{4'b0101, 32'h00C100A1, 1'b1, 1'b1, 8'hA0, 2'd0, 4'b1111};
    vecs[8]  = '{4'b0101, 32'h00C200A2, 1'b1, 1'b1, 8'hC0, 2'd2, 4'b1111};
    vecs[9]  = '{4'b0101, 32'h00C300A3, 1'b1, 1'b1, 8'hA1, 2'd0, 4'b1111};
    vecs[10] = '{4'b0000, 32'h0,        1'b1, 1'b1, 8'hC1, 2'd2, 4'b1111};
    vecs[11] = '{4'b0000, 32'h0,        1'b1, 1'b1, 8'hA2, 2'd0, 4'b1111};
    vecs[12] = '{4'b0000, 32'h0,        1'b1, 1'b1, 8'hC2, 2'd2, 4'b1111};
    vecs[13] = '{4'b0000, 32'h0,        1'b1, 1'b1, 8'hA3, 2'd0, 4'b1111};
    vecs[14] = '{4'b0000, 32'h0,        1'b1, 1'b1, 8'hC3, 2'd2, 4'b1111};
    vecs[15] = '{4'b0000, 32'h0,        1'b1, 1'b0, 8'h00, 2'd0, 4'b1111};

`ifdef QUAD_LANE_MERGE_PARITY_EN
    in_par = 4'b0000;
`endif

    // Reset with all lanes asserting valid
    rst_n = 1'b0;
    applyStimulus(4'b1111, 32'h13121110, 1'b1);
    step();
    step();
    checkOutput("rst_in_ready", 32'(in_ready), 32'h0000000F);
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_out_data", 32'(out_data), 32'h0);
    checkOutput("rst_out_lane", 32'(out_lane), 32'h0);
    checkOutput("rst_lane_full", 32'(lane_full), 32'h0);
    checkOutput("rst_drop_err", 32'(drop_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 16; v++) begin
      applyStimulus(vecs[v].valid, vecs[v].data, vecs[v].ready);
      step();
      checkOutput($sformatf("vec%0d_valid", v), 32'(out_valid), 32'(vecs[v].exp_valid));
      checkOutput($sformatf("vec%0d_in_ready", v), 32'(in_ready), 32'(vecs[v].exp_in_ready));
      if (vecs[v].exp_valid) begin
        checkOutput($sformatf("vec%0d_data", v), 32'(out_data), 32'(vecs[v].exp_data));
        checkOutput($sformatf("vec%0d_lane", v), 32'(out_lane), 32'(vecs[v].exp_lane));
      end
    end

    // Backpressure: five pushes on lane 1 fill output register plus FIFO
    doReset();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b0010, 32'(8'h30 + k) << 8, 1'b0);
      step();
    end
    applyStimulus(4'b0000, 32'h0, 1'b0);
    checkOutput("bp_lane_full", 32'(lane_full), 32'h2);
    checkOutput("bp_in_ready", 32'(in_ready), 32'hD);
    checkOutput("bp_out_valid", 32'(out_valid), 32'h1);
    checkOutput("bp_out_data", 32'(out_data), 32'h30);
    checkOutput("bp_drop_before", 32'(drop_err), 32'h0);
    applyStimulus(4'b0010, 32'h00003500, 1'b0);
    step();
    applyStimulus(4'b0000, 32'h0, 1'b0);
    checkOutput("bp_drop_after", 32'(drop_err), 32'h1);
    checkOutput("bp_still_full", 32'(lane_full), 32'h2);

    // Stall hold for 10 cycles, then drain in order
    for (int k = 0; k < 10; k++) begin
      step();
      checkOutput($sformatf("stall%0d_data", k), 32'(out_data), 32'h30);
      checkOutput($sformatf("stall%0d_lane", k), 32'(out_lane), 32'h1);
      checkOutput($sformatf("stall%0d_valid", k), 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      step();
      checkOutput($sformatf("drain%0d_data", k), 32'(out_data), 32'(8'h30 + k));
      checkOutput($sformatf("drain%0d_lane", k), 32'(out_lane), 32'h1);
      checkOutput($sformatf("drain%0d_valid", k), 32'(out_valid), 32'h1);
    end
    checkOutput("drain_not_full", 32'(lane_full), 32'h0);
    checkOutput("drain_drop_sticky", 32'(drop_err), 32'h1);
    step();
    checkOutput("drain_empty", 32'(out_valid), 32'h0);

    // Asynchronous reset mid-burst
    applyStimulus(4'b1111, 32'h44332211, 1'b0);
    step();
    step();
    applyStimulus(4'b0000, 32'h0, 1'b0);
    checkOutput("burst_valid", 32'(out_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("arst_in_ready", 32'(in_ready), 32'hF);
    checkOutput("arst_lane_full", 32'(lane_full), 32'h0);
    checkOutput("arst_drop_err", 32'(drop_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b1000, 32'h5A000000, 1'b1);
    step();
    applyStimulus(4'b0000, 32'h0, 1'b1);
    checkOutput("post_arst_first_edge", 32'(out_valid), 32'h0);
    step();
    checkOutput("post_arst_valid", 32'(out_valid), 32'h1);
    checkOutput("post_arst_data", 32'(out_data), 32'h5A);
    checkOutput("post_arst_lane", 32'(out_lane), 32'h3);
    step();
    checkOutput("post_arst_drained", 32'(out_valid), 32'h0);

`ifdef QUAD_LANE_MERGE_PARITY_EN
    doReset();
    checkOutput("par_err_reset", 32'(par_err), 32'h0);
    in_par = 4'b0000;
    applyStimulus(4'b0010, 32'h00000700, 1'b1);
    step();
    applyStimulus(4'b0000, 32'h0, 1'b1);
    checkOutput("par_err_set", 32'(par_err), 32'h1);
    step();
    checkOutput("par_out_data", 32'(out_data), 32'h07);
    checkOutput("par_out_lane", 32'(out_lane), 32'h1);
    checkOutput("par_out_par", 32'(out_par), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
